// File: rtl/cpu_pkg.sv
// Shared definitions for the operand/issue stage and its register file.
package cpu_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned NREGS = 4;
    localparam int unsigned AW    = $clog2(NREGS);

    typedef logic [AW-1:0] reg_idx_t;

    typedef enum logic [2:0] {
        AluAdd  = 3'b000,
        AluSub  = 3'b001,
        AluSrl  = 3'b010,
        AluNor  = 3'b011,
        AluNand = 3'b100,
        AluSll  = 3'b110
    } alu_op_t;

endpackage

// File: rtl/regfile_nr.sv
// NREGS x DW register file: two asynchronous read ports, one synchronous write port,
// register 0 hardwired to zero.
module regfile_nr
    import cpu_pkg::*;
#(
    parameter int unsigned DW    = cpu_pkg::DW,
    parameter int unsigned NREGS = cpu_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] ra1_i,
    input  logic [$clog2(NREGS)-1:0] ra2_i,
    output logic [DW-1:0]            rd1_o,
    output logic [DW-1:0]            rd2_o,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] wa_i,
    input  logic [DW-1:0]            wd_i
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [DW-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = (ra1_i == AW'(0)) ? '0 : mem_q[ra1_i];
        rd2_o = (ra2_i == AW'(0)) ? '0 : mem_q[ra2_i];
    end

endmodule

// File: rtl/operand_stage.sv
// Register-read / issue stage in front of the ALU: busy scoreboard, RAW/WAW stall, one-entry
// output register. Define OPERAND_STAGE_BYPASS_EN to forward same-cycle writeback data.
module operand_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DW    = cpu_pkg::DW,
    parameter int unsigned NREGS = cpu_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREGS)-1:0] in_rs1,
    input  logic [$clog2(NREGS)-1:0] in_rs2,
    input  logic [$clog2(NREGS)-1:0] in_rd,
    input  logic [2:0]               in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_rs1,
    output logic [DW-1:0]            out_rs2,
    output logic [2:0]               out_ctrl,
    output logic [$clog2(NREGS)-1:0] out_rd,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic [DW-1:0]            wb_data,
    output logic [NREGS-1:0]         busy
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam logic [NREGS-1:0] OneHot0 = {{(NREGS-1){1'b0}}, 1'b1};

    logic [NREGS-1:0] busy_q, busy_d, busy_eff;
    logic [NREGS-1:0] wb_mask, set_mask;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [2:0]       out_ctrl_q, out_ctrl_d;
    logic [AW-1:0]    out_rd_q, out_rd_d;
    logic [DW-1:0]    rf_rd1, rf_rd2;
    logic [DW-1:0]    op1, op2;
    logic             hazard, accept;

    regfile_nr #(
        .DW    (DW),
        .NREGS (NREGS)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (in_rs1),
        .ra2_i (in_rs2),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2),
        .we_i  (wb_en),
        .wa_i  (wb_rd),
        .wd_i  (wb_data)
    );

    // Register 0 never appears in either mask, so it can never be busy.
    always_comb begin
        wb_mask  = (wb_en && (wb_rd != '0)) ? (OneHot0 << wb_rd) : '0;
        set_mask = (accept && (in_rd != '0)) ? (OneHot0 << in_rd) : '0;
    end

`ifdef OPERAND_STAGE_BYPASS_EN
    always_comb begin
        busy_eff = busy_q & ~wb_mask;
        op1      = wb_mask[in_rs1] ? wb_data : rf_rd1;
        op2      = wb_mask[in_rs2] ? wb_data : rf_rd2;
    end
`else
    always_comb begin
        busy_eff = busy_q;
        op1      = rf_rd1;
        op2      = rf_rd2;
    end
`endif

    always_comb begin
        hazard   = busy_eff[in_rs1] || busy_eff[in_rs2] || busy_eff[in_rd];
        in_ready = !hazard && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    // Set beats clear when writeback and a new claim hit the same register.
    always_comb begin
        busy_d      = (busy_q & ~wb_mask) | set_mask;
        out_valid_d = out_valid_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_ctrl_d  = out_ctrl_q;
        out_rd_d    = out_rd_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_rs1_d   = op1;
            out_rs2_d   = op2;
            out_ctrl_d  = in_ctrl;
            out_rd_d    = in_rd;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_ctrl_q  <= '0;
            out_rd_q    <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
            out_ctrl_q  <= out_ctrl_d;
            out_rd_q    <= out_rd_d;
        end
    end

    always_comb begin
        out_valid = out_valid_q;
        out_rs1   = out_rs1_q;
        out_rs2   = out_rs2_q;
        out_ctrl  = out_ctrl_q;
        out_rd    = out_rd_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage; expected ALU transfers go through a scoreboard queue.
module tb_operand_stage;
    import cpu_pkg::*;

    typedef struct packed {
        logic [7:0] rs1;
        logic [7:0] rs2;
        logic [2:0] ctrl;
        logic [1:0] rd;
    } exp_t;

    logic       clk, rst_n;
    logic       in_valid, in_ready;
    logic [1:0] in_rs1, in_rs2, in_rd;
    logic [2:0] in_ctrl;
    logic       out_valid, out_ready;
    logic [7:0] out_rs1, out_rs2;
    logic [2:0] out_ctrl;
    logic [1:0] out_rd;
    logic       wb_en;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic [3:0] busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    operand_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rs1   (out_rs1),
        .out_rs2   (out_rs2),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every transfer toward the ALU must match the oldest pushed expectation.
    always @(negedge clk) begin
        exp_t got, exp;
        if (rst_n && out_valid && out_ready) begin
            got = '{rs1: out_rs1, rs2: out_rs2, ctrl: out_ctrl, rd: out_rd};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h, required no transfer", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL sb_transfer: got %h, required %h", got, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeback(input logic [1:0] rd, input logic [7:0] data);
        wb_en = 1'b1; wb_rd = rd; wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic drive(input logic [1:0] rs1, input logic [1:0] rs2, input logic [1:0] rd,
                         input logic [2:0] ctrl);
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_ctrl = ctrl;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_valid, busy, out_rs1, out_rs2, out_ctrl, out_rd} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b busy=%b rs1=%h rs2=%h ctrl=%b rd=%0d, required 0",
                     out_valid, busy, out_rs1, out_rs2, out_ctrl, out_rd);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        writeback(2'd1, 8'h5A);
        writeback(2'd2, 8'h03);
        out_ready = 1'b1;
        drive(2'd1, 2'd2, 2'd3, AluAdd);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_in_ready: got %b, required 1", in_ready);
        end
        sb.push_back('{rs1: 8'h5A, rs2: 8'h03, ctrl: 3'b000, rd: 2'd3});
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || busy !== 4'b1000) begin
            errors++;
            $display("FAIL basic_issue: got v=%b busy=%b, required v=1 busy=1000", out_valid, busy);
        end
        tick();
        writeback(2'd3, 8'h5D);
        checks++;
        if (busy !== 4'b0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got v=%b busy=%b, required v=0 busy=0000", out_valid, busy);
        end
    endtask

    task automatic test_raw();
        out_ready = 1'b1;
        drive(2'd0, 2'd0, 2'd1, AluSub);
        sb.push_back('{rs1: 8'h00, rs2: 8'h00, ctrl: 3'b001, rd: 2'd1});
        tick();
        drive(2'd1, 2'd2, 2'd2, AluAdd);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL raw_stall: got in_ready=%b, required 0", in_ready);
            end
            tick();
        end
        wb_en = 1'b1; wb_rd = 2'd1; wb_data = 8'h77;
        @(negedge clk);
`ifdef OPERAND_STAGE_BYPASS_EN
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL raw_bypass_accept: got in_ready=%b, required 1", in_ready);
        end
        sb.push_back('{rs1: 8'h77, rs2: 8'h03, ctrl: 3'b000, rd: 2'd2});
        tick();
        wb_en = 1'b0;
`else
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL raw_wb_cycle: got in_ready=%b, required 0", in_ready);
        end
        tick();
        wb_en = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL raw_after_wb: got in_ready=%b, required 1", in_ready);
        end
        sb.push_back('{rs1: 8'h77, rs2: 8'h03, ctrl: 3'b000, rd: 2'd2});
        tick();
`endif
        in_valid = 1'b0;
        tick();
        writeback(2'd2, 8'h03);
        checks++;
        if (busy !== 4'b0000) begin
            errors++; $display("FAIL raw_busy_clear: got %b, required 0000", busy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(2'd1, 2'd2, 2'd3, AluSrl);
        sb.push_back('{rs1: 8'h77, rs2: 8'h03, ctrl: 3'b010, rd: 2'd3});
        tick();
        drive(2'd2, 2'd0, 2'd0, AluNor);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rs1 !== 8'h77
                || out_rs2 !== 8'h03 || out_ctrl !== 3'b010 || out_rd !== 2'd3) begin
                errors++;
                $display("FAIL bp_hold: got rdy=%b v=%b rs1=%h rs2=%h ctrl=%b rd=%0d, required 0 1 77 03 010 3",
                         in_ready, out_valid, out_rs1, out_rs2, out_ctrl, out_rd);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got in_ready=%b, required 1", in_ready);
        end
        sb.push_back('{rs1: 8'h03, rs2: 8'h00, ctrl: 3'b011, rd: 2'd0});
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 3'b011) begin
            errors++;
            $display("FAIL bp_next: got v=%b ctrl=%b, required v=1 ctrl=011", out_valid, out_ctrl);
        end
        tick();
        writeback(2'd3, 8'h11);
    endtask

    task automatic test_r0();
        out_ready = 1'b1;
        drive(2'd0, 2'd1, 2'd0, AluNand);
        wb_en = 1'b1; wb_rd = 2'd0; wb_data = 8'hFF;
        sb.push_back('{rs1: 8'h00, rs2: 8'h77, ctrl: 3'b100, rd: 2'd0});
        tick();
        wb_en = 1'b0;
        checks++;
        if (busy !== 4'b0000) begin
            errors++; $display("FAIL r0_busy: got %b, required 0000", busy);
        end
        for (int i = 0; i < 2; i++) begin
            drive(2'd0, 2'd0, 2'd0, (i == 0) ? 3'b101 : 3'b111);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL r0_b2b: got in_ready=%b, required 1", in_ready);
            end
            sb.push_back('{rs1: 8'h00, rs2: 8'h00, ctrl: (i == 0) ? 3'b101 : 3'b111, rd: 2'd0});
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_set_clear();
        out_ready = 1'b1;
        drive(2'd0, 2'd0, 2'd2, AluAdd);
        sb.push_back('{rs1: 8'h00, rs2: 8'h00, ctrl: 3'b000, rd: 2'd2});
        tick();
        drive(2'd0, 2'd2, 2'd2, AluSll);
        wb_en = 1'b1; wb_rd = 2'd2; wb_data = 8'h44;
`ifndef OPERAND_STAGE_BYPASS_EN
        tick();
        wb_en = 1'b0;
`endif
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL sc_accept: got in_ready=%b, required 1", in_ready);
        end
        sb.push_back('{rs1: 8'h00, rs2: 8'h44, ctrl: 3'b110, rd: 2'd2});
        tick();
        wb_en = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 4'b0100) begin
            errors++; $display("FAIL sc_set_wins: got busy=%b, required 0100", busy);
        end
        tick();
        writeback(2'd2, 8'h44);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        drive(2'd0, 2'd0, 2'd1, AluAdd);
        sb.push_back('{rs1: 8'h00, rs2: 8'h00, ctrl: 3'b000, rd: 2'd1});
        tick();
        drive(2'd0, 2'd0, 2'd2, AluSub);
        sb.push_back('{rs1: 8'h00, rs2: 8'h00, ctrl: 3'b001, rd: 2'd2});
        tick();
        out_ready = 1'b0;
        drive(2'd1, 2'd0, 2'd3, AluAdd);
        @(negedge clk);
        checks++;
        if (busy !== 4'b0110 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: got busy=%b rdy=%b v=%b, required 0110 0 1", busy, in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 4'b0000 || out_valid !== 1'b0 || out_rd !== 2'd0) begin
            errors++;
            $display("FAIL ar_async: got busy=%b v=%b rd=%0d, required 0000 0 0", busy, out_valid, out_rd);
        end
        sb.delete();
        in_valid = 1'b0;
        tick();
        #3 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        drive(2'd1, 2'd2, 2'd3, AluAdd);
        sb.push_back('{rs1: 8'h00, rs2: 8'h00, ctrl: 3'b000, rd: 2'd3});
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_ctrl = '0;
        out_ready = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        #12 rst_n = 1'b1;
        test_reset();
        tick();
        test_basic();
        test_raw();
        test_backpressure();
        test_r0();
        test_set_clear();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Register-read and issue stage directly upstream of the 8-bit ALU.
- Accepts decoded instructions (source/destination register indices plus 3-bit ALU ctrl), reads a small register file and tracks outstanding writes with a busy scoreboard.
- Stalls on RAW/WAW hazards, then presents registered rs1/rs2/ctrl/rd to the ALU over a valid/ready handshake.
- Owns the architectural register file; the writeback port comes from the ALU result path.

Parameters:
- DW, 8, data width of registers and operands.
- NREGS, 4, number of architectural registers. Register 0 reads as zero, ignores writes and is never busy.
- AW, $clog2(NREGS), register index width. Localparam, derived, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- in_rs1  in  AW  source 1 index.
- in_rs2  in  AW  source 2 index.
- in_rd  in  AW  destination index.
- in_ctrl  in  3  ALU op (000 add, 001 sub, 010 srl, 011 nor, 100 nand, 110 sll).
- out_valid  out  1  operands valid toward ALU.
- out_ready  in  1  ALU consumes.
- out_rs1  out  DW  operand 1.
- out_rs2  out  DW  operand 2.
- out_ctrl  out  3  ALU op.
- out_rd  out  AW  destination, carried for writeback.
- wb_en  in  1  writeback strobe.
- wb_rd  in  AW  writeback index.
- wb_data  in  DW  writeback value.
- busy  out  NREGS  scoreboard, bit i = write pending to register i.

Behaviour:
- Reset (async assert, sync release): all registers 0, busy 0, out_valid 0, out_rs1/out_rs2/out_ctrl/out_rd 0.
- Output register: one entry, no skid. A transfer occurs when out_valid && out_ready.
- Hazard condition: hazard = busy[in_rs1] || busy[in_rs2] || busy[in_rd], each term after the bypass clearing below.
- Stall: in_ready = !hazard && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Combinational path: in_ready depends combinationally on in_rs*/in_rd and wb_*.
- On accept (registered, 1-cycle latency):
  - out_rs1/out_rs2 = register-file read, or wb_data when bypassing.
  - out_ctrl and out_rd are loaded.
  - out_valid is set to 1.
  - busy[in_rd] is set, unless in_rd == 0.
- No accept and transfer occurs: out_valid goes to 0; output data holds.
- Writeback: when wb_en, regfile[wb_rd] <= wb_data and busy[wb_rd] is cleared at the edge. wb_rd == 0 is ignored. A write to a non-busy register is legal and simply writes.
- Same-cycle clear and set on the same register: set wins; the register ends busy.
- in_valid held while stalled: fields must stay stable. The stage does not latch them.
- Unsupported ctrl values (101, 111) are passed through unchanged; the ALU defines the result.
- Reset mid-operation clears the scoreboard and drops the in-flight output.

Optional Feature:
- Macro OPERAND_STAGE_BYPASS_EN.
- Defined:
  - wb_en && wb_rd == in_rsX (nonzero) treats that source as not busy this cycle.
  - The operand is taken from wb_data.
  - The same applies to in_rd (WAW clears same cycle).
- Undefined:
  - No forwarding; busy bits are used as registered.
  - A dependent instruction issues one cycle after the writeback edge and reads the register file.

Decomposition:
- Shared package cpu_pkg:
  - alu_op_t enum for the 3-bit ctrl encodings.
  - DW and NREGS defaults.
  - Typedef reg_idx_t.
- One natural sub-module: regfile_nr.
  - NREGS x DW.
  - Two async read ports and one sync write port.
  - r0 hardwired zero.
  - Async active-low reset to 0.
- Scoreboard, hazard logic and output register stay in operand_stage.

Test Plan:
- Reset, then wb r1 = 0x5A, r2 = 0x03; issue rs1=1, rs2=2, rd=3, ctrl=000 -> next cycle out_valid=1, out_rs1=0x5A, out_rs2=0x03, out_ctrl=000, out_rd=3, busy=4'b1000.
- RAW: issue rd=1, then rs1=1 with no writeback -> in_ready=0 held; wb r1=0x77. With BYPASS_EN: accept in the wb cycle, out_rs1=0x77. Without: accept next cycle, out_rs1=0x77.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, outputs stable for 5 cycles; out_ready=1 -> transfer, next instruction accepted the same cycle.
- r0: issue rd=0, rs1=0; wb r0=0xFF -> out_rs1=0x00 and busy[0] stays 0; a back-to-back instruction reading r0 never stalls.
- Same-cycle set/clear: r2 busy, wb r2 in the cycle an instruction with rd=2 is accepted (BYPASS_EN) -> busy[2]=1 afterwards.
- Async reset: assert rst_n mid-stall with busy=4'b0110 -> busy=0, out_valid=0 immediately, before any clock edge.
